// File: rtl/spm_pkg.sv
// Shared scratchpad definitions: enable levels, forwarding policy encodings
// and clear-FSM state encoding.
package spm_pkg;
   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam int FWD_OLD = 0;
   localparam int FWD_NEW = 1;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } spm_state_e;
endpackage

// File: rtl/spm_init_fsm.sv
// Clear sequencer: walks the clear address 0..DEPTH-1 once per clear request,
// then returns to RUN.
module spm_init_fsm
   import spm_pkg::*;
#(
   parameter int ADDR_W         = 12,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);
   localparam spm_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

   spm_state_e        state, state_nxt;
   logic [ADDR_W-1:0] addr_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= RST_STATE;
         clr_addr <= '0;
      end else begin
         state    <= state_nxt;
         clr_addr <= addr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = clr_addr;
      busy      = DISABLE;
      clr_we    = DISABLE;
      case (state)
         ST_CLEAR: begin
            busy   = ENABLE;
            clr_we = ENABLE;
            // last word written: park the counter instead of wrapping
            if (clr_addr == '1) begin
               state_nxt = ST_RUN;
               addr_nxt  = '0;
            end else begin
               addr_nxt = clr_addr + ADDR_W'(1);
            end
         end
         default: begin
            if (init) begin
               state_nxt = ST_CLEAR;
               addr_nxt  = '0;
            end
         end
      endcase
   end
endmodule

// File: rtl/spm_dpram_bank.sv
// True dual-port scratchpad bank with byte enables, A-priority write merge,
// configurable cross-port forwarding and a hardware clear sequencer.
module spm_dpram_bank
   import spm_pkg::*;
#(
   parameter  int DATA_W         = 32,
   parameter  int ADDR_W         = 12,
   parameter  int CLEAR_ON_RESET = 1,
   parameter  int FWD_MODE       = 1,
   localparam int BE_W           = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   output logic              busy,
   output logic [7:0]        coll_cnt,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [BE_W-1:0]   a_be,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_ack,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [BE_W-1:0]   b_be,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_ack
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              a_wr, b_wr, a_rd, b_rd, same, ww;
   logic [DATA_W-1:0] a_old, b_old, a_fwd, b_fwd;

   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] base,
                                               input logic [DATA_W-1:0] wd,
                                               input logic [BE_W-1:0]   be);
      logic [DATA_W-1:0] r;
      r = base;
      for (int i = 0; i < BE_W; i++)
         if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
      return r;
   endfunction

   spm_init_fsm #(
      .ADDR_W        (ADDR_W),
      .CLEAR_ON_RESET(CLEAR_ON_RESET)
   ) u_init (
      .clk     (clk),
      .reset   (reset),
      .init    (init),
      .busy    (busy),
      .clr_we  (clr_we),
      .clr_addr(clr_addr)
   );

   assign a_wr  = a_req & a_we & ~busy;
   assign b_wr  = b_req & b_we & ~busy;
   assign a_rd  = a_req & ~a_we & ~busy;
   assign b_rd  = b_req & ~b_we & ~busy;
   assign same  = (a_addr == b_addr);
   assign ww    = a_wr & b_wr & same;
   assign a_old = mem[a_addr];
   assign b_old = mem[b_addr];
   assign a_fwd = (FWD_MODE == FWD_NEW && b_wr && same) ? merge(a_old, b_wdata, b_be) : a_old;
   assign b_fwd = (FWD_MODE == FWD_NEW && a_wr && same) ? merge(b_old, a_wdata, a_be) : b_old;

   // A's lane writes are issued after B's so A wins on lanes both enabled
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else begin
         for (int i = 0; i < BE_W; i++) begin
            if (b_wr && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
            if (a_wr && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_ack    <= 1'b0;
         b_ack    <= 1'b0;
         a_rdata  <= '0;
         b_rdata  <= '0;
         coll_cnt <= '0;
      end else begin
         a_ack <= a_req & ~busy;
         b_ack <= b_req & ~busy;
         if (a_rd) a_rdata <= a_fwd;
         if (b_rd) b_rdata <= b_fwd;
         if (ww && coll_cnt != 8'hFF) coll_cnt <= coll_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_spm_dpram_bank.sv
// Bench for spm_dpram_bank: two instances (old-data and new-data forwarding)
// share stimulus and are checked every cycle against a behavioural model.
module tb_spm_dpram_bank;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        init = 1'b0;
   logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [3:0]  a_be = '0, b_be = '0, a_addr = '0, b_addr = '0;
   logic [31:0] a_wdata = '0, b_wdata = '0;

   // index = FWD_MODE of the instance
   logic        busy_o [2];
   logic [7:0]  coll_o [2];
   logic [31:0] ard_o  [2];
   logic [31:0] brd_o  [2];
   logic        aack_o [2];
   logic        back_o [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      spm_dpram_bank #(
         .DATA_W(32), .ADDR_W(4), .CLEAR_ON_RESET(1), .FWD_MODE(g)
      ) u_dut (
         .clk(clk), .reset(reset), .init(init),
         .busy(busy_o[g]), .coll_cnt(coll_o[g]),
         .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
         .a_wdata(a_wdata), .a_rdata(ard_o[g]), .a_ack(aack_o[g]),
         .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
         .b_wdata(b_wdata), .b_rdata(brd_o[g]), .b_ack(back_o[g])
      );
   end

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] base, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = base;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
      return r;
   endfunction

   // behavioural model: memory array, remaining clear cycles, expected outputs
   logic [31:0] m_mem [DEPTH];
   int          m_left;
   int          m_coll;
   logic        m_aack, m_back;
   logic [31:0] m_ard [2];
   logic [31:0] m_brd [2];
   logic [31:0] m_ao, m_bo;
   logic        m_aw, m_bw;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_left = DEPTH;
         m_coll = 0;
         m_aack = 1'b0;
         m_back = 1'b0;
         for (int k = 0; k < 2; k++) begin
            m_ard[k] = '0;
            m_brd[k] = '0;
         end
      end else if (m_left > 0) begin
         m_mem[DEPTH - m_left] = '0;
         m_left = m_left - 1;
         m_aack = 1'b0;
         m_back = 1'b0;
      end else begin
         m_aack = a_req;
         m_back = b_req;
         m_aw   = a_req && a_we;
         m_bw   = b_req && b_we;
         m_ao   = m_mem[a_addr];
         m_bo   = m_mem[b_addr];
         if (a_req && !a_we) begin
            m_ard[0] = m_ao;
            m_ard[1] = (m_bw && b_addr == a_addr) ? merge(m_ao, b_wdata, b_be) : m_ao;
         end
         if (b_req && !b_we) begin
            m_brd[0] = m_bo;
            m_brd[1] = (m_aw && a_addr == b_addr) ? merge(m_bo, a_wdata, a_be) : m_bo;
         end
         if (m_aw && m_bw && a_addr == b_addr) begin
            if (m_coll < 255) m_coll = m_coll + 1;
            m_mem[a_addr] = merge(merge(m_ao, b_wdata, b_be), a_wdata, a_be);
         end else begin
            if (m_bw) m_mem[b_addr] = merge(m_bo, b_wdata, b_be);
            if (m_aw) m_mem[a_addr] = merge(m_ao, a_wdata, a_be);
         end
         if (init) m_left = DEPTH;
      end
   end

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("mdl_busy[%0d]", g),    32'(busy_o[g]), 32'(m_left > 0));
         chk($sformatf("mdl_a_ack[%0d]", g),   32'(aack_o[g]), 32'(m_aack));
         chk($sformatf("mdl_b_ack[%0d]", g),   32'(back_o[g]), 32'(m_back));
         chk($sformatf("mdl_coll[%0d]", g),    32'(coll_o[g]), 32'(m_coll));
         chk($sformatf("mdl_a_rdata[%0d]", g), ard_o[g], m_ard[g]);
         chk($sformatf("mdl_b_rdata[%0d]", g), brd_o[g], m_brd[g]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic we, input logic [3:0] addr, input logic [31:0] d,
                        input logic [3:0] be);
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d; a_be = be;
   endtask

   task automatic set_b(input logic we, input logic [3:0] addr, input logic [31:0] d,
                        input logic [3:0] be);
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d; b_be = be;
   endtask

   task automatic idle();
      a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0;
   endtask

   // steps until busy drops; no ack may appear meanwhile; expects DEPTH cycles
   task automatic wait_clear(input string name);
      int n;
      n = 0;
      while (busy_o[1] && n < 40) begin
         tick();
         n++;
         chk({name, "_no_ack"}, 32'(aack_o[1] | back_o[1] | aack_o[0] | back_o[0]), 32'h0);
      end
      chk({name, "_len"}, n, DEPTH);
   endtask

   initial begin
      #1 reset = 1'b0;
      tick();
      tick();
      chk("rst_busy",  32'(busy_o[1]), 32'h1);
      chk("rst_coll",  32'(coll_o[1]), 32'h0);
      chk("rst_ack",   32'(aack_o[1]), 32'h0);
      chk("rst_rdata", ard_o[1], 32'h0);
      reset = 1'b1;
      wait_clear("clear_after_reset");

      // first read after clear
      set_a(1'b0, 4'hF, 32'h0, 4'h0);
      tick();
      idle();
      chk("rd15_ack",   32'(aack_o[1]), 32'h1);
      chk("rd15_rdata", ard_o[1], 32'h0);
      tick();
      chk("ack_pulse",  32'(aack_o[1]), 32'h0);

      // partial byte-enable overwrite, then a zero-enable write
      set_a(1'b1, 4'h5, 32'hAABBCCDD, 4'hF);
      tick();
      set_a(1'b1, 4'h5, 32'h11223344, 4'h5);
      tick();
      chk("wr_keeps_rdata", ard_o[1], 32'h0);
      set_a(1'b1, 4'h5, 32'h0, 4'h0);
      tick();
      idle();
      set_b(1'b0, 4'h5, 32'h0, 4'h0);
      tick();
      idle();
      chk("be_merge_new", brd_o[1], 32'hAA22CC44);
      chk("be_merge_old", brd_o[0], 32'hAA22CC44);

      // write/write collision
      set_a(1'b1, 4'h7, 32'hFFFFFFFF, 4'h3);
      set_b(1'b1, 4'h7, 32'h00000000, 4'hF);
      tick();
      idle();
      chk("coll_one", 32'(coll_o[1]), 32'h1);
      set_a(1'b0, 4'h7, 32'h0, 4'h0);
      tick();
      chk("coll_word", ard_o[1], 32'h0000FFFF);
      set_a(1'b0, 4'h5, 32'h0, 4'h0);
      tick();
      chk("b2b_rd0", ard_o[1], 32'hAA22CC44);
      set_a(1'b0, 4'h7, 32'h0, 4'h0);
      tick();
      chk("b2b_rd1", ard_o[0], 32'h0000FFFF);
      set_a(1'b1, 4'h7, 32'hFFFFFFFF, 4'h3);
      set_b(1'b1, 4'h7, 32'h00000000, 4'hF);
      for (int i = 0; i < 300; i++) tick();
      idle();
      tick();
      chk("coll_sat", 32'(coll_o[1]), 32'd255);

      // cross-port read-during-write
      set_a(1'b1, 4'h3, 32'h12345678, 4'hF);
      tick();
      set_a(1'b1, 4'h3, 32'hCAFEBABE, 4'hF);
      set_b(1'b0, 4'h3, 32'h0, 4'h0);
      tick();
      idle();
      chk("rdw_fwd_new", brd_o[1], 32'hCAFEBABE);
      chk("rdw_fwd_old", brd_o[0], 32'h12345678);
      set_b(1'b1, 4'h3, 32'h00000000, 4'h8);
      set_a(1'b0, 4'h3, 32'h0, 4'h0);
      tick();
      idle();
      chk("rdw_part_new", ard_o[1], 32'h00FEBABE);
      chk("rdw_part_old", ard_o[0], 32'hCAFEBABE);
      set_a(1'b0, 4'h3, 32'h0, 4'h0);
      set_b(1'b0, 4'h3, 32'h0, 4'h0);
      tick();
      idle();
      chk("rr_a", ard_o[0], 32'h00FEBABE);
      chk("rr_b", brd_o[1], 32'h00FEBABE);

      // init with a request held high
      set_a(1'b0, 4'h5, 32'h0, 4'h0);
      init = 1'b1;
      tick();
      init = 1'b0;
      chk("init_cycle_ack", 32'(aack_o[1]), 32'h1);
      chk("init_busy",      32'(busy_o[1]), 32'h1);
      wait_clear("clear_after_init");
      tick();
      idle();
      chk("post_init_ack", 32'(aack_o[1]), 32'h1);
      for (int i = 0; i < DEPTH; i++) begin
         set_a(1'b0, 4'(i), 32'h0, 4'h0);
         tick();
         chk($sformatf("zero_word_%0d", i), ard_o[1], 32'h0);
      end
      idle();
      chk("coll_kept", 32'(coll_o[0]), 32'd255);

      // reset in the middle of a clear with a request pending
      set_a(1'b1, 4'h0, 32'hDEADBEEF, 4'hF);
      tick();
      idle();
      init = 1'b1;
      tick();
      init = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      set_a(1'b0, 4'h0, 32'h0, 4'h0);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_ack",   32'(aack_o[1] | aack_o[0]), 32'h0);
      chk("mid_rst_rdata", ard_o[1], 32'h0);
      chk("mid_rst_coll",  32'(coll_o[1]), 32'h0);
      chk("mid_rst_busy",  32'(busy_o[1]), 32'h1);
      tick();
      reset = 1'b1;
      wait_clear("clear_after_mid_rst");
      tick();
      idle();
      chk("reclr_ack",   32'(aack_o[1]), 32'h1);
      chk("reclr_addr0", ard_o[1], 32'h0);
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
